// File: rtl/sl_transmitter.sv
// Two-line serial transmitter: each bit is a low pulse on sl1 (one) or sl0 (zero),
// followed by an odd-parity symbol, a stop symbol on both lines and an idle gap.
module sl_transmitter #(
    parameter int PULSE_LEN = 16,
    parameter int GAP_LEN   = 16,
    parameter int IDLE_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic        tx_err,
    output logic        sl0,
    output logic        sl1
);

    typedef enum logic [2:0] {
        IDLE,
        DATA_LOW,
        DATA_HIGH,
        PAR_LOW,
        PAR_HIGH,
        STOP_LOW,
        STOP_HIGH,
        GAP
    } state_t;

    localparam logic [7:0] P_LD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] G_LD = 8'(GAP_LEN - 1);
    localparam logic [7:0] I_LD = 8'(IDLE_LEN - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [5:0]  bit_idx;
    logic [5:0]  len;
    logic [31:0] data;
    logic        par;

    logic [31:0] mask;
    logic [31:0] masked;
    logic        legal;

    always_comb begin
        mask = '1;
        if (tx_len < 6'd32) mask = (32'd1 << tx_len) - 32'd1;
        masked = tx_data & mask;
        legal  = (tx_len >= 6'd8) && (tx_len <= 6'd32);
    end

    // data holds the bits still to be sent, already shifted past the one on the line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            len      <= '0;
            data     <= '0;
            par      <= 1'b0;
            sl0      <= 1'b1;
            sl1      <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_valid) begin
                        if (legal) begin
                            data     <= masked >> 1;
                            len      <= tx_len;
                            par      <= ~^masked;
                            bit_idx  <= '0;
                            cnt      <= P_LD;
                            sl0      <= masked[0];
                            sl1      <= ~masked[0];
                            tx_ready <= 1'b0;
                            state    <= DATA_LOW;
                        end else begin
                            tx_err <= 1'b1;
                        end
                    end
                end
                DATA_LOW: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                        cnt   <= G_LD;
                        state <= DATA_HIGH;
                    end
                end
                DATA_HIGH: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        cnt <= P_LD;
                        if (bit_idx == len - 6'd1) begin
                            sl0   <= par;
                            sl1   <= ~par;
                            state <= PAR_LOW;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                            data    <= data >> 1;
                            sl0     <= data[0];
                            sl1     <= ~data[0];
                            state   <= DATA_LOW;
                        end
                    end
                end
                PAR_LOW: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                        cnt   <= G_LD;
                        state <= PAR_HIGH;
                    end
                end
                PAR_HIGH: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        sl0   <= 1'b0;
                        sl1   <= 1'b0;
                        cnt   <= P_LD;
                        state <= STOP_LOW;
                    end
                end
                STOP_LOW: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                        cnt   <= G_LD;
                        state <= STOP_HIGH;
                    end
                end
                STOP_HIGH: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        cnt   <= I_LD;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else begin
                        tx_ready <= 1'b1;
                        tx_done  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: the driver queues expected symbols and pulses,
// a negedge monitor decodes the lines and checks kind, start cycle and pulse length.
module tb_sl_transmitter;

    localparam int P   = 16;
    localparam int G   = 16;
    localparam int I   = 16;
    localparam int SYM = P + G;

    // event kinds: 0/1 data or parity bit, 2 stop, 3 tx_done, 4 tx_err
    typedef struct {
        int kind;
        int at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_err;
    logic        sl0;
    logic        sl1;

    sl_transmitter #(.PULSE_LEN(P), .GAP_LEN(G), .IDLE_LEN(I)) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_len(tx_len),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .sl0(sl0),
        .sl1(sl1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_evt(input int k);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d want none (cycle %0d)", k, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.at);
        end
    endtask

    int in_sym = 0;
    int slen = 0;

    always @(negedge clk) begin
        if (!reset) begin
            in_sym = 0;
        end else begin
            if (in_sym == 0 && (!sl0 || !sl1)) begin
                expect_evt((!sl0 && !sl1) ? 2 : (!sl1 ? 1 : 0));
                in_sym = 1;
                slen = 1;
            end else if (in_sym != 0) begin
                if (!sl0 || !sl1) slen++;
                else begin
                    chk("pulse_len", slen, P);
                    in_sym = 0;
                end
            end
            if (tx_done) expect_evt(3);
            if (tx_err) expect_evt(4);
        end
    end

    task automatic push_word(input logic [31:0] d, input logic [5:0] l, input int n);
        int ones;
        int len;
        len = int'(l);
        ones = 0;
        if (len >= 8 && len <= 32) begin
            for (int i = 0; i < len; i++) begin
                q.push_back('{int'(d[i]), n + 1 + i * SYM});
                ones += int'(d[i]);
            end
            q.push_back('{(ones % 2 == 0) ? 1 : 0, n + 1 + len * SYM});
            q.push_back('{2, n + 1 + (len + 1) * SYM});
            q.push_back('{3, n + 1 + (len + 2) * SYM + I});
        end else begin
            q.push_back('{4, n + 1});
        end
    endtask

    // called at a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [31:0] d, input logic [5:0] l, input bit hold);
        int w;
        w = 0;
        tx_data = d;
        tx_len = l;
        tx_valid = 1'b1;
        while (!tx_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready 0 want 1");
            tx_valid = 1'b0;
            return;
        end
        push_word(d, l, cyc);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_sl0", sl0, 1);
        chk("rst_sl1", sl1, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        send(32'h0000_0001, 6'd8, 1'b0);
        drain();
        send(32'h0000_0003, 6'd8, 1'b0);
        drain();
        send(32'hFFFF_FFFF, 6'd32, 1'b0);
        drain();
        send(32'hFF00_00A5, 6'd8, 1'b0);
        drain();

        send(32'h0000_0055, 6'd7, 1'b0);
        chk("err_pulse", tx_err, 1);
        chk("err_ready", tx_ready, 1);
        chk("err_sl0", sl0, 1);
        chk("err_sl1", sl1, 1);
        drain();
        send(32'h0000_00FF, 6'd40, 1'b0);
        drain();

        send(32'h0000_A5C3, 6'd16, 1'b0);
        repeat (5 * SYM + 5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_sl0", sl0, 1);
        chk("abort_sl1", sl1, 1);
        chk("abort_ready", tx_ready, 1);
        chk("abort_done", tx_done, 0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        send(32'h0000_1B2D, 6'd14, 1'b0);
        drain();

        send(32'h0000_005A, 6'd8, 1'b1);
        send(32'h0000_1234, 6'd13, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
